mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle MIPS main control FSM: the producer side of the ALU's `ALUControl` interface.
- Sequences each instruction through fetch/decode/execute/memory/writeback and drives datapath enables, mux selects and the 4-bit `alu_control` into the ALU.
- Consumes the ALU `zero` flag for branch resolution.
- Sits between the instruction register (opcode/funct fields) and the multi-cycle datapath.

Parameters:
- `STATE_W`, 4, width of state register and `state_dbg`.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26], stable from DECODE until FETCH.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- pc_en  out  1  PC load = pc_write | (pc_write_cond & zero).
- pc_write  out  1  unconditional PC write.
- pc_write_cond  out  1  branch PC write qualifier.
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR.
- reg_dst  out  1  destination register: 0=rt, 1=rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0=PC, 1=A.
- alu_src_b  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2.
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- alu_control  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct.
- state_dbg  out  STATE_W  current state encoding.

Behaviour:
- Register and output style:
  - Only the state register is sequential; it uses async reset on `rst_n` low.
  - All outputs are Moore decodes of state, except `pc_en` (uses `zero`) and `alu_control` in EXEC (uses `funct`).
- Reset: state=FETCH(0).
  - FETCH outputs apply immediately after reset.
  - Any other output not named for FETCH is 0 during reset.
  - Reset mid-instruction abandons it; no strobe may persist past reset assertion.
- States (encoding) and asserted outputs; all unlisted outputs are 0:
  - FETCH(0): mem_read, ir_write, alu_src_a=0, alu_src_b=01, alu_control=0010, pc_source=00, pc_write. Next: DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_control=0010. Next by opcode:
    - 100011/101011 -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - otherwise FETCH with illegal_op=1.
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_control=0010. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD(3): mem_read, i_or_d=1. Next: MEMWB.
  - MEMWB(4): reg_write, mem_to_reg=1, reg_dst=0. Next: FETCH.
  - MEMWR(5): mem_write, i_or_d=1. Next: FETCH.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_control by funct:
    - 100000 -> 0010
    - 100010 -> 0110
    - 100100 -> 0000
    - 100101 -> 0001
    - 101010 -> 0111
    - otherwise alu_control=0010, illegal_op=1, next FETCH (no writeback).
    - Legal funct: next ALUWB.
  - ALUWB(7): reg_write, reg_dst=1, mem_to_reg=0. Next: FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_control=0110, pc_write_cond, pc_source=01. Next: FETCH.
  - ADDIEX(9): alu_src_a=1, alu_src_b=10, alu_control=0010. Next: ADDIWB.
  - ADDIWB(10): reg_write, reg_dst=0, mem_to_reg=0. Next: FETCH.
  - JUMP(11): pc_write, pc_source=10. Next: FETCH.
  - Encodings 12-15: unreachable. Next FETCH, illegal_op=1.
- Latency in cycles, FETCH inclusive:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Illegal opcode: 2, then refetch.
- Branch: pc_en=zero in BRANCH only; zero is ignored in every other state.
- Mutual exclusion:
  - mem_read and mem_write are never both 1.
  - reg_write is never 1 in the same cycle as mem_write.

Decomposition:
- Package `mc_ctrl_pkg` holds:
  - state encodings
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU control codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  - alu_src_b and pc_source select codes
- One sub-module, `alu_ctrl_decode`: combinational mapping from (alu_op class, funct) to (alu_control, illegal). Shared with any future single-cycle variant.

Test Plan:
- Reset: rst_n low mid-MEMRD -> state_dbg=0 asynchronously; mem_read=1, ir_write=1, pc_write=1, mem_write=0 after release.
- lw: opcode=100011 -> state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4; i_or_d=1 in state 3.
- R-type: opcode=0, funct=101010 -> alu_control=0111 in EXEC, reg_dst=1 in ALUWB. Repeat with funct=100010 -> alu_control=0110.
- beq: zero=1 -> pc_en=1 in BRANCH; zero=0 -> pc_en=0. In both cases, next state is FETCH after 3 cycles.
- j then sw back-to-back: state sequence 0,1,11,0,1,2,5,0. pc_source=10 in JUMP; mem_write=1 only in state 5.
- Illegal: opcode=111111 -> illegal_op pulses one cycle in DECODE, then FETCH. funct=000000 R-type -> illegal_op in EXEC, no reg_write ever asserted.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS main control.
// Holds the FSM state encodings, instruction field constants (opcode and
// funct), the 4-bit ALU control codes, the ALU operation class used by
// alu_ctrl_decode, and the alu_src_b / pc_source select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operation class requested by the main FSM. ALUOP_NONE drives 0000
  // so states that do not use the ALU leave alu_control at zero.
  typedef enum logic [1:0] {
    ALUOP_NONE  = 2'd0,
    ALUOP_ADD   = 2'd1,
    ALUOP_SUB   = 2'd2,
    ALUOP_FUNCT = 2'd3
  } aluop_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational mapping from ALU operation class and the
// instruction funct field to the 4-bit ALU control code.
//   alu_op      in  operation class from the main control
//   funct       in  IR[5:0], only consulted for ALUOP_FUNCT
//   alu_control out ALU control code
//   illegal     out funct not supported (only for ALUOP_FUNCT)
module alu_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = 4'b0000;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: begin
            // Unsupported funct still presents a harmless add to the ALU.
            alu_control = ALU_ADD;
            illegal     = 1'b1;
          end
        endcase
      end
      default: alu_control = 4'b0000;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS main control FSM.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// enables, mux selects and alu_control. Only the state register is
// sequential; outputs are Moore decodes of state, except pc_en (uses zero)
// and alu_control in EXEC (uses funct).
//   clk, rst_n          clock, asynchronous active-low reset (-> FETCH)
//   opcode, funct       IR fields, stable from DECODE until next FETCH
//   zero                ALU zero flag, only meaningful in BRANCH
//   pc_en .. alu_control datapath controls
//   illegal_op          one-cycle pulse on unsupported opcode/funct
//   state_dbg           current state encoding
module mc_control
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pc_en,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [3:0]         alu_control,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state, next_state;
  aluop_t alu_op;
  logic   fn_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  alu_ctrl_decode u_alu_dec (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control),
    .illegal     (fn_illegal)
  );

  always_comb begin
    next_state    = S_FETCH;
    alu_op        = ALUOP_NONE;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here in case the op is beq.
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_FUNCT;
        illegal_op = fn_illegal;
        // Unsupported funct abandons the instruction without writeback.
        next_state = fn_illegal ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: illegal_op = 1'b1;
    endcase
  end

  // pc_write_cond is only set in BRANCH, so zero has no effect elsewhere.
  assign pc_en     = pc_write | (pc_write_cond & zero);
  assign state_dbg = STATE_W'(state);

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized self-checking bench for mc_control. Each
// instruction is expanded into its expected state walk from its class, and
// every cycle the observed controls are compared with the value the state
// table describes for that step.
module tb_mc_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_control;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  mc_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_control(alu_control),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] ctl_obs;
  assign ctl_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                    ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                    alu_src_b, pc_source, alu_control, illegal_op, pc_en};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  function automatic bit legal_op(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  function automatic bit legal_fn(input logic [5:0] fn);
    return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
           fn == 6'b100101 || fn == 6'b101010;
  endfunction

  function automatic logic [3:0] fn_code(input logic [5:0] fn);
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected state walk of one instruction, FETCH first.
  task automatic build_seq(input logic [5:0] op, input logic [5:0] fn);
    exp_q.delete();
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    case (op)
      6'b100011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
      6'b101011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
      6'b000000: begin
        exp_q.push_back(4'd6);
        if (legal_fn(fn)) exp_q.push_back(4'd7);
      end
      6'b000100: exp_q.push_back(4'd8);
      6'b001000: begin exp_q.push_back(4'd9); exp_q.push_back(4'd10); end
      6'b000010: exp_q.push_back(4'd11);
      default: ;
    endcase
  endtask

  // Control vector the state table prescribes for a step.
  function automatic logic [19:0] exp_ctl(input logic [3:0] st,
      input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, pcs;
    logic [3:0] aluc;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aluc = 4'b0000;
    case (st)
      4'd0:  begin mr = 1; irw = 1; asb = 2'b01; aluc = 4'b0010; pw = 1; end
      4'd1:  begin asb = 2'b11; aluc = 4'b0010; ill = !legal_op(op); end
      4'd2:  begin asa = 1; asb = 2'b10; aluc = 4'b0010; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iod = 1; end
      4'd6:  begin asa = 1; aluc = fn_code(fn); ill = !legal_fn(fn); end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin asa = 1; aluc = 4'b0110; pwc = 1; pcs = 2'b01; end
      4'd9:  begin asa = 1; asb = 2'b10; aluc = 4'b0010; end
      4'd10: rw = 1;
      4'd11: begin pw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aluc, ill,
            pw | (pwc & z)};
  endfunction

  // driver: entered at a negedge inside a FETCH cycle; leaves at the negedge
  // of the cycle after the last checked step. zmode 0/1 forces zero, 2 random.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int max_steps);
    int n;
    logic [3:0] st;
    build_seq(op, fn);
    opcode = op;
    funct  = fn;
    n = 0;
    while (exp_q.size() > 0 && n < max_steps) begin
      st = exp_q.pop_front();
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      check("state", 32'(state_dbg), 32'(st));
      check("ctl", 32'(ctl_obs), 32'(exp_ctl(st, op, fn, zero)));
      check("mem_rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
      check("reg_wr_mem_wr_excl", 32'(reg_write & mem_write), 32'd0);
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
    #3;
    check("reset_state", 32'(state_dbg), 32'd0);
    check("reset_ctl", 32'(ctl_obs), 32'(exp_ctl(4'd0, 6'd0, 6'd0, 1'b0)));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // lw, then reset while in MEMRD
    run_instr(6'b100011, 6'd0, 2, 100);
    run_instr(6'b100011, 6'd0, 2, 3);
    check("in_memrd", 32'(state_dbg), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state_dbg), 32'd0);
    check("async_rst_mem_read", 32'(mem_read), 32'd1);
    check("async_rst_i_or_d", 32'(i_or_d), 32'd0);
    check("async_rst_mem_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ir_write", 32'(ir_write), 32'd1);
    check("post_rst_pc_write", 32'(pc_write), 32'd1);

    // directed: R-type slt/sub, beq taken/not, j then sw, illegals
    run_instr(6'b000000, 6'b101010, 2, 100);
    run_instr(6'b000000, 6'b100010, 2, 100);
    run_instr(6'b000100, 6'd0, 1, 100);
    run_instr(6'b000100, 6'd0, 0, 100);
    run_instr(6'b000010, 6'd0, 2, 100);
    run_instr(6'b101011, 6'd0, 2, 100);
    run_instr(6'b111111, 6'd0, 2, 100);
    run_instr(6'b000000, 6'b000000, 2, 100);
    run_instr(6'b001000, 6'd0, 2, 100);

    // random instruction stream
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (legal_op(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom_range(0, 63));
      else                           fn = fns[$urandom_range(0, 4)];
      run_instr(op, fn, 2, 100);
    end
    // the stream must end back in FETCH
    #1 check("final_fetch", 32'(state_dbg), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
